// File: rtl/nw_traceback_reader.sv
// nw_traceback_reader
//
// Walks the traceback coordinate list left in memory by the Needleman-Wunsch
// grid and turns each step into an aligned character pair on a valid/ready
// stream. Entries are {x, y} words (x indexes s2, y indexes s1). They are
// stored from (LENGTH-1, LENGTH-1) at address 0 down to (0,0), so pairs come
// out from the end of the alignment toward its start.
//
// Optional feature macro: NW_READER_SCORE_EN
//   defined     - score accumulates MATCH/MISMATCH/INDEL weights per pair
//   not defined - no score adder or register, score is tied to 0
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start, count       begin a decode of count entries (sampled in IDLE/ERR)
//   s1, s2             strings, char i at [i*CWIDTH +: CWIDTH], stable while busy
//   ren, raddr, rdata  memory read port, rdata valid one cycle after ren
//   out_valid/ready    output stream handshake
//   out_op             00 TOP, 01 LEFT, 10 CORNER
//   out_c1, out_c2     characters (gap side is 0)
//   out_match          CORNER with equal characters
//   out_last           final pair of the alignment
//   busy, done, error  status; done pulses one cycle after the last handshake
//   score              signed running score (wraps at SWIDTH)
module nw_traceback_reader #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8,
    parameter int MEM_SIZE    = 9,
    parameter int BYTE_SIZE   = 2 * CORD_LENGTH,
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int INDEL       = -1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [MEM_SIZE:0]          count,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    output logic                       ren,
    output logic [MEM_SIZE-1:0]        raddr,
    input  logic [BYTE_SIZE-1:0]       rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_op,
    output logic [CWIDTH-1:0]          out_c1,
    output logic [CWIDTH-1:0]          out_c2,
    output logic                       out_match,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [SWIDTH-1:0]          score
);

    localparam logic [1:0] OP_TOP    = 2'b00;
    localparam logic [1:0] OP_LEFT   = 2'b01;
    localparam logic [1:0] OP_CORNER = 2'b10;

    localparam logic [CORD_LENGTH:0]   LEN_C     = (CORD_LENGTH+1)'(LENGTH);
    localparam logic [CORD_LENGTH-1:0] LAST_C    = CORD_LENGTH'(LENGTH - 1);
    localparam logic [CORD_LENGTH-1:0] ONE_C     = CORD_LENGTH'(1);
    localparam logic [MEM_SIZE:0]      ONE_N     = (MEM_SIZE+1)'(1);
    localparam logic [MEM_SIZE:0]      TWO_N     = (MEM_SIZE+1)'(2);
    localparam logic [MEM_SIZE:0]      MAX_COUNT = {1'b1, {MEM_SIZE{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_LD0,
        S_LD,
        S_EMIT,
        S_FIN,
        S_ERR
    } state_t;

    state_t                  state_reg;
    logic [MEM_SIZE:0]       count_reg;
    logic [MEM_SIZE:0]       idx_reg;
    logic [CORD_LENGTH-1:0]  cur_x_reg, cur_y_reg;
    logic [CORD_LENGTH-1:0]  nxt_x_reg, nxt_y_reg;

    logic                    out_valid_reg;
    logic [1:0]              op_reg;
    logic [CWIDTH-1:0]       c1_reg, c2_reg;
    logic                    match_reg;
    logic                    last_reg;
    logic                    done_reg;
    logic                    error_reg;

    // ------------------------------------------------------------------
    // String unpacking and character lookup at the current coordinate
    // ------------------------------------------------------------------
    logic [CWIDTH-1:0] s1_chars [LENGTH];
    logic [CWIDTH-1:0] s2_chars [LENGTH];

    genvar gi;
    generate
        for (gi = 0; gi < LENGTH; gi++) begin : g_chars
            assign s1_chars[gi] = s1[gi*CWIDTH +: CWIDTH];
            assign s2_chars[gi] = s2[gi*CWIDTH +: CWIDTH];
        end
    endgenerate

    logic [CWIDTH-1:0] cur_c1, cur_c2;

    always_comb begin
        cur_c1 = '0;
        cur_c2 = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (cur_y_reg == CORD_LENGTH'(k)) cur_c1 = s1_chars[k];
            if (cur_x_reg == CORD_LENGTH'(k)) cur_c2 = s2_chars[k];
        end
    end

    // ------------------------------------------------------------------
    // Step classification of the word on rdata against cur
    // ------------------------------------------------------------------
    logic [CORD_LENGTH-1:0] rd_x, rd_y;
    logic in_range, step_x, step_y, same_x, same_y;
    logic is_corner, is_top, is_left, step_ok, head_ok, tail_ok;

    assign rd_x = rdata[BYTE_SIZE-1 -: CORD_LENGTH];
    assign rd_y = rdata[CORD_LENGTH-1:0];

    assign in_range  = ({1'b0, rd_x} < LEN_C) && ({1'b0, rd_y} < LEN_C);
    assign step_x    = (cur_x_reg != '0) && (rd_x == cur_x_reg - ONE_C);
    assign step_y    = (cur_y_reg != '0) && (rd_y == cur_y_reg - ONE_C);
    assign same_x    = (rd_x == cur_x_reg);
    assign same_y    = (rd_y == cur_y_reg);
    assign is_corner = step_x && step_y;
    assign is_top    = same_x && step_y;
    assign is_left   = step_x && same_y;
    assign step_ok   = in_range && (is_corner || is_top || is_left);
    assign head_ok   = (rd_x == LAST_C) && (rd_y == LAST_C);
    assign tail_ok   = (cur_x_reg == '0) && (cur_y_reg == '0);

    logic start_ok;
    assign start_ok = (count != '0) && (count <= MAX_COUNT);

    // Entry index that the next LD state needs on rdata.
    logic [MEM_SIZE:0] idx_plus2;
    assign idx_plus2 = idx_reg + TWO_N;

    // ------------------------------------------------------------------
    // Read port. The read for the next entry is issued in the same cycle
    // as the EMIT handshake so its data lands exactly in LD, giving one
    // pair every two cycles; with out_ready low nothing is read.
    // ------------------------------------------------------------------
    always_comb begin
        ren   = 1'b0;
        raddr = '0;
        case (state_reg)
            S_RD0: begin
                ren = 1'b1;
            end
            S_LD0: begin
                // Entry 1 is fetched while entry 0 is being checked; a bad
                // head entry only costs a discarded read.
                ren   = (count_reg > ONE_N);
                raddr = MEM_SIZE'(1);
            end
            S_EMIT: begin
                if (out_ready && !last_reg && (idx_plus2 < count_reg)) begin
                    ren   = 1'b1;
                    raddr = idx_plus2[MEM_SIZE-1:0];
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Main state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            idx_reg       <= '0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            nxt_x_reg     <= '0;
            nxt_y_reg     <= '0;
            out_valid_reg <= 1'b0;
            op_reg        <= '0;
            c1_reg        <= '0;
            c2_reg        <= '0;
            match_reg     <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        if (start_ok) begin
                            state_reg <= S_RD0;
                            count_reg <= count;
                            idx_reg   <= '0;
                            error_reg <= 1'b0;
                        end else begin
                            state_reg <= S_ERR;
                            error_reg <= 1'b1;
                        end
                    end
                end

                S_RD0: begin
                    state_reg <= S_LD0;
                end

                S_LD0: begin
                    cur_x_reg <= rd_x;
                    cur_y_reg <= rd_y;
                    if (!head_ok) begin
                        state_reg <= S_ERR;
                        error_reg <= 1'b1;
                    end else if (count_reg == ONE_N) begin
                        state_reg <= S_FIN;
                    end else begin
                        state_reg <= S_LD;
                    end
                end

                S_LD: begin
                    nxt_x_reg <= rd_x;
                    nxt_y_reg <= rd_y;
                    if (!step_ok) begin
                        state_reg <= S_ERR;
                        error_reg <= 1'b1;
                    end else begin
                        out_valid_reg <= 1'b1;
                        last_reg      <= 1'b0;
                        if (is_corner) begin
                            op_reg    <= OP_CORNER;
                            c1_reg    <= cur_c1;
                            c2_reg    <= cur_c2;
                            match_reg <= (cur_c1 == cur_c2);
                        end else if (is_top) begin
                            op_reg    <= OP_TOP;
                            c1_reg    <= cur_c1;
                            c2_reg    <= '0;
                            match_reg <= 1'b0;
                        end else begin
                            op_reg    <= OP_LEFT;
                            c1_reg    <= '0;
                            c2_reg    <= cur_c2;
                            match_reg <= 1'b0;
                        end
                        state_reg <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (last_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            cur_x_reg <= nxt_x_reg;
                            cur_y_reg <= nxt_y_reg;
                            idx_reg   <= idx_reg + ONE_N;
                            state_reg <= (idx_plus2 < count_reg) ? S_LD : S_FIN;
                        end
                    end
                end

                S_FIN: begin
                    // The origin cell itself is the final CORNER pair.
                    if (tail_ok) begin
                        out_valid_reg <= 1'b1;
                        op_reg        <= OP_CORNER;
                        c1_reg        <= s1_chars[0];
                        c2_reg        <= s2_chars[0];
                        match_reg     <= (s1_chars[0] == s2_chars[0]);
                        last_reg      <= 1'b1;
                        state_reg     <= S_EMIT;
                    end else begin
                        state_reg <= S_ERR;
                        error_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Running score
    // ------------------------------------------------------------------
`ifdef NW_READER_SCORE_EN
    logic [SWIDTH-1:0] score_reg;
    logic [SWIDTH-1:0] weight;

    always_comb begin
        weight = SWIDTH'(INDEL);
        if (op_reg == OP_CORNER) begin
            weight = match_reg ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_reg <= '0;
        end else if ((state_reg == S_IDLE || state_reg == S_ERR) && start && start_ok) begin
            score_reg <= '0;
        end else if (state_reg == S_EMIT && out_ready) begin
            score_reg <= score_reg + weight;
        end
    end

    assign score = score_reg;
`else
    assign score = '0;
`endif

    assign out_valid = out_valid_reg;
    assign out_op    = op_reg;
    assign out_c1    = c1_reg;
    assign out_c2    = c2_reg;
    assign out_match = match_reg;
    assign out_last  = last_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign busy      = (state_reg != S_IDLE) && (state_reg != S_ERR);

endmodule

// File: tb/tb_nw_traceback_reader.sv
// Self-checking bench for nw_traceback_reader with LENGTH=3.
// A table of decode scenarios (memory image, strings, expected pair stream,
// expected error/score) is applied in a loop; backpressure, bad count and
// mid-decode reset are hand-written sequences.
module tb_nw_traceback_reader;

    localparam int LENGTH      = 3;
    localparam int CWIDTH      = 2;
    localparam int SWIDTH      = 16;
    localparam int CORD_LENGTH = 8;
    localparam int MEM_SIZE    = 9;
    localparam int BYTE_SIZE   = 2 * CORD_LENGTH;
    localparam int NSCN        = 5;

    logic                       clk;
    logic                       reset;
    logic                       start;
    logic [MEM_SIZE:0]          count;
    logic [LENGTH*CWIDTH-1:0]   s1, s2;
    logic                       ren;
    logic [MEM_SIZE-1:0]        raddr;
    logic [BYTE_SIZE-1:0]       rdata;
    logic                       out_valid, out_ready;
    logic [1:0]                 out_op;
    logic [CWIDTH-1:0]          out_c1, out_c2;
    logic                       out_match, out_last;
    logic                       busy, done, error;
    logic [SWIDTH-1:0]          score;

    nw_traceback_reader #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
        .CORD_LENGTH(CORD_LENGTH), .MEM_SIZE(MEM_SIZE), .BYTE_SIZE(BYTE_SIZE),
        .MATCH(1), .MISMATCH(-1), .INDEL(-1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .s1(s1), .s2(s2), .ren(ren), .raddr(raddr), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_c1(out_c1), .out_c2(out_c2), .out_match(out_match),
        .out_last(out_last), .busy(busy), .done(done), .error(error),
        .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Traceback memory model: registered read, one cycle latency.
    logic [BYTE_SIZE-1:0] mem [0:511];
    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    logic [7:0] cur_pair;
    assign cur_pair = {out_op, out_c1, out_c2, out_match, out_last};

    typedef struct {
        logic [5:0]       s1;
        logic [5:0]       s2;
        logic [3:0][15:0] mem;
        int               count;
        int               n_pairs;
        logic [3:0][7:0]  pairs;
        bit               exp_err;
        int               err_cyc;
        logic [15:0]      score;
    } scn_t;

    scn_t tbl [NSCN];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [5:0] STR_ID  = {2'd2, 2'd1, 2'd0};
    localparam logic [5:0] STR_ALT = {2'd1, 2'd2, 2'd0};

    function automatic logic [15:0] cord(input int x, input int y);
        return {8'(x), 8'(y)};
    endfunction

    function automatic logic [7:0] pr(input int op, input int c1, input int c2,
                                      input int m, input int l);
        return {2'(op), 2'(c1), 2'(c2), 1'(m), 1'(l)};
    endfunction

    function automatic logic [15:0] exp_score(input int v);
        logic [15:0] r;
        r = 16'(v);
`ifndef NW_READER_SCORE_EN
        r = '0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic init_tbl();
        // 0: identical path, three matching CORNERs
        tbl[0].s1 = STR_ID; tbl[0].s2 = STR_ID;
        tbl[0].mem = {16'h0, cord(0,0), cord(1,1), cord(2,2)};
        tbl[0].count = 3; tbl[0].n_pairs = 3;
        tbl[0].pairs = {8'h0, pr(2,0,0,1,1), pr(2,1,1,1,0), pr(2,2,2,1,0)};
        tbl[0].exp_err = 0; tbl[0].err_cyc = -1; tbl[0].score = exp_score(3);
        // 1: same path, s2 permuted -> two mismatches then a match
        tbl[1].s1 = STR_ID; tbl[1].s2 = STR_ALT;
        tbl[1].mem = {16'h0, cord(0,0), cord(1,1), cord(2,2)};
        tbl[1].count = 3; tbl[1].n_pairs = 3;
        tbl[1].pairs = {8'h0, pr(2,0,0,1,1), pr(2,1,2,0,0), pr(2,2,1,0,0)};
        tbl[1].exp_err = 0; tbl[1].err_cyc = -1; tbl[1].score = exp_score(-1);
        // 2: illegal step (2,2)->(0,2)
        tbl[2].s1 = STR_ID; tbl[2].s2 = STR_ID;
        tbl[2].mem = {16'h0, 16'h0, cord(0,2), cord(2,2)};
        tbl[2].count = 2; tbl[2].n_pairs = 0;
        tbl[2].pairs = '0;
        tbl[2].exp_err = 1; tbl[2].err_cyc = 4; tbl[2].score = exp_score(0);
        // 3: gap path, started from ERR
        tbl[3].s1 = STR_ID; tbl[3].s2 = STR_ID;
        tbl[3].mem = {cord(0,0), cord(1,1), cord(1,2), cord(2,2)};
        tbl[3].count = 4; tbl[3].n_pairs = 4;
        tbl[3].pairs = {pr(2,0,0,1,1), pr(2,1,1,1,0), pr(0,2,0,0,0), pr(1,0,2,0,0)};
        tbl[3].exp_err = 0; tbl[3].err_cyc = -1; tbl[3].score = exp_score(0);
        // 4: path ends at (1,0) -> error from FIN, no last pair
        tbl[4].s1 = STR_ID; tbl[4].s2 = STR_ID;
        tbl[4].mem = {16'h0, cord(1,0), cord(1,1), cord(2,2)};
        tbl[4].count = 3; tbl[4].n_pairs = 2;
        tbl[4].pairs = {8'h0, 8'h0, pr(0,1,0,0,0), pr(2,2,2,1,0)};
        tbl[4].exp_err = 1; tbl[4].err_cyc = 8; tbl[4].score = exp_score(0);
    endtask

    task automatic load_scn(input int k);
        for (int a = 0; a < 4; a++) mem[a] = tbl[k].mem[a];
        s1    = tbl[k].s1;
        s2    = tbl[k].s2;
        count = (MEM_SIZE+1)'(tbl[k].count);
    endtask

    // Cycle numbering: the posedge that samples start ends cycle T; cyc=n
    // is the negedge inside cycle T+n.
    task automatic run_scn(input int k);
        int cyc, np, first_v, hs1, err_c, done_c, last_c;
        bit got_done, got_err;
        np = 0; first_v = -1; hs1 = -1; err_c = -1; done_c = -1; last_c = -1;
        got_done = 0; got_err = 0;
        load_scn(k);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk($sformatf("scn%0d T+1 ren/raddr/busy/error", k),
            {ren, raddr, busy, error}, {1'b1, 9'd0, 1'b1, 1'b0});
        while (cyc < 60 && !got_done && !got_err) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2)
                chk($sformatf("scn%0d T+2 ren/raddr", k), {ren, raddr}, {1'b1, 9'd1});
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && out_ready) begin
                $display("scn%0d pair %0d: op=%0d c1=%0d c2=%0d match=%0d last=%0d score=%0d",
                         k, np, out_op, out_c1, out_c2, out_match, out_last, $signed(score));
                if (np < tbl[k].n_pairs)
                    chk($sformatf("scn%0d pair%0d {op,c1,c2,match,last}", k, np),
                        cur_pair, tbl[k].pairs[np]);
                else begin
                    n_checks++; n_fail++;
                    $display("FAIL scn%0d extra pair: got %0h expected none", k, cur_pair);
                end
                if (np == 1) hs1 = cyc;
                if (out_last) last_c = cyc;
                np++;
            end
            if (done) begin got_done = 1; done_c = cyc; end
            if (error) begin got_err = 1; err_c = cyc; end
        end
        chk($sformatf("scn%0d pair count", k), np, tbl[k].n_pairs);
        chk($sformatf("scn%0d error seen", k), got_err, tbl[k].exp_err);
        chk($sformatf("scn%0d done seen", k), got_done, !tbl[k].exp_err);
        if (tbl[k].n_pairs > 0)
            chk($sformatf("scn%0d first out_valid cycle", k), first_v, 4);
        if (tbl[k].n_pairs >= 3)
            chk($sformatf("scn%0d second handshake cycle", k), hs1, 6);
        if (tbl[k].err_cyc >= 0)
            chk($sformatf("scn%0d error cycle", k), err_c, tbl[k].err_cyc);
        if (got_done)
            chk($sformatf("scn%0d done one cycle after last", k), done_c, last_c + 1);
        chk($sformatf("scn%0d score", k), score, tbl[k].score);
        @(negedge clk);
        chk($sformatf("scn%0d after end done/busy/valid/ren/error", k),
            {done, busy, out_valid, ren, error}, {4'b0000, tbl[k].exp_err});
    endtask

    task automatic bp_seq();
        int np;
        bit got_done;
        load_scn(0);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);          // cycle T+4, first EMIT
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp stall%0d valid/pair/ren", c),
                {out_valid, cur_pair, ren}, {1'b1, tbl[0].pairs[0], 1'b0});
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release ren/raddr", {ren, raddr}, {1'b1, 9'd2});
        np = 1;
        got_done = 0;
        for (int c = 0; c < 30 && !got_done; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) np++;
            if (done) got_done = 1;
        end
        chk("bp total pairs", np, 3);
        chk("bp done seen", got_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic reset_seq();
        bit saw_done;
        load_scn(0);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);          // cycle T+6, second EMIT
        chk("rst second EMIT valid/pair", {out_valid, cur_pair}, {1'b1, tbl[0].pairs[1]});
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst outputs A", {ren, raddr, out_valid, out_op, out_c1, out_c2, out_match, out_last}, '0);
        chk("rst outputs B", {busy, done, error, score}, '0);
        reset = 1'b0;
        out_ready = 1'b1;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || out_valid || busy) saw_done = 1;
        end
        chk("rst no done/valid/busy afterwards", saw_done, 1'b0);
    endtask

    task automatic bad_count_seq();
        count = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("count0 error/ren/busy", {error, ren, busy}, 3'b100);
        count = (MEM_SIZE+1)'(513);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("count513 error/ren/busy", {error, ren, busy}, 3'b100);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; count = '0; s1 = '0; s2 = '0; out_ready = 1'b0;
        for (int a = 0; a < 512; a++) mem[a] = '0;
        init_tbl();
        repeat (2) @(negedge clk);
        chk("reset state A", {ren, raddr, out_valid, out_op, out_c1, out_c2, out_match, out_last}, '0);
        chk("reset state B", {busy, done, error, score}, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", {busy, done, error, ren, out_valid}, '0);

        bad_count_seq();
        for (int k = 0; k < NSCN; k++) run_scn(k);
        bp_seq();
        reset_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
